// File: rtl/alu_operand_b_queue_pkg.sv
// alu_operand_b_queue_pkg: operand-B source encodings and opcode constants shared by the queue
package alu_operand_b_queue_pkg;
    typedef enum logic [2:0] {
        SRC_REG     = 3'd0,
        SRC_PC_INC  = 3'd1,
        SRC_IMM     = 3'd2,
        SRC_IMM_SH2 = 3'd3,
        SRC_LUI     = 3'd4,
        SRC_SHAMT   = 3'd5
    } alu_src_b_e;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    // Logical-immediate instructions take a zero-extended immediate; everything else sign-extends
    function automatic logic is_zext_op(input logic [5:0] op);
        return op inside {OP_ANDI, OP_ORI, OP_XORI};
    endfunction
endpackage

// File: rtl/alu_operand_b_queue_if.sv
// alu_operand_b_queue_if: request and result handshakes between decode, operand queue and ALU
interface alu_operand_b_queue_if #(parameter int DATA_W = 32, parameter int IMM_W = 16);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] register_b;
    logic [IMM_W-1:0]  immediate;
    logic [5:0]        opcode;
    logic [4:0]        shamt;
    logic [2:0]        alu_src_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_b;
    logic              illegal_sel;
    modport master (
        output in_valid, register_b, immediate, opcode, shamt, alu_src_b, out_ready,
        input  in_ready, out_valid, alu_b, illegal_sel
    );
    modport slave (
        input  in_valid, register_b, immediate, opcode, shamt, alu_src_b, out_ready,
        output in_ready, out_valid, alu_b, illegal_sel
    );
endinterface

// File: rtl/alu_operand_b_queue_operand_b_gen.sv
// operand_b_gen: combinational immediate extension and operand-B source select
module operand_b_gen
    import alu_operand_b_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int PC_INC = 4
) (
    input  logic [DATA_W-1:0] register_b,
    input  logic [IMM_W-1:0]  immediate,
    input  logic [5:0]        opcode,
    input  logic [4:0]        shamt,
    input  logic [2:0]        alu_src_b,
    output logic [DATA_W-1:0] operand,
    output logic              illegal
);
    logic [DATA_W-1:0] ext;
    assign ext = {{(DATA_W-IMM_W){is_zext_op(opcode) ? 1'b0 : immediate[IMM_W-1]}}, immediate};
    // Pick the operand source; reserved selects yield zero and flag themselves
    always_comb begin
        operand = '0;
        illegal = 1'b0;
        case (alu_src_b)
            SRC_REG:     operand = register_b;
            SRC_PC_INC:  operand = DATA_W'(PC_INC);
            SRC_IMM:     operand = ext;
            SRC_IMM_SH2: operand = ext << 2;
            SRC_LUI:     operand = {immediate, {(DATA_W-IMM_W){1'b0}}};
            SRC_SHAMT:   operand = DATA_W'(shamt);
            default:     illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_operand_b_queue.sv
// alu_operand_b_queue: prepares ALU operand B and buffers it in a small valid/ready FIFO
module alu_operand_b_queue
    import alu_operand_b_queue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int DEPTH  = 2,
    parameter int PC_INC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    alu_operand_b_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] operand;
    logic              illegal;
    logic              push;
    logic              pop;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    operand_b_gen #(.DATA_W(DATA_W), .IMM_W(IMM_W), .PC_INC(PC_INC)) u_gen (
        .register_b (bus.register_b),
        .immediate  (bus.immediate),
        .opcode     (bus.opcode),
        .shamt      (bus.shamt),
        .alu_src_b  (bus.alu_src_b),
        .operand    (operand),
        .illegal    (illegal)
    );
    assign bus.in_ready  = count != (PW+1)'(DEPTH);
    assign bus.out_valid = count != '0;
    assign bus.alu_b     = bus.out_valid ? mem[rd_ptr] : '0;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    // Pointers wrap naturally since DEPTH is a power of two; flush drops everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    // Storage needs no reset: alu_b is masked to zero whenever the queue is empty
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= operand;
    end
    // Sticky record that a reserved select was ever accepted; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.illegal_sel <= 1'b0;
        else if (push && illegal) bus.illegal_sel <= 1'b1;
    end
endmodule

// File: tb/tb_alu_operand_b_queue.sv
// tb_alu_operand_b_queue: scoreboard bench with directed and randomized operand requests
module tb_alu_operand_b_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [31:0] cur_exp = '0;
    logic [31:0] exp_q [$];
    logic [31:0] pend = '0;
    logic pend_v = 1'b0;
    logic pend_ill = 1'b0;
    logic fl_s = 1'b0;
    logic ill_m = 1'b0;
    logic rnd_or = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    int p0;

    alu_operand_b_queue_if #(.DATA_W(32), .IMM_W(16)) bus ();

    alu_operand_b_queue #(.DATA_W(32), .IMM_W(16), .DEPTH(2), .PC_INC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] rb, input logic [15:0] imm,
                                          input logic [5:0] op, input logic [4:0] sh, input logic [2:0] sel);
        longint e;
        e = (op == 6'd12 || op == 6'd13 || op == 6'd14) ? longint'(imm) : longint'($signed(imm));
        case (sel)
            3'd0: return rb;
            3'd1: return 32'd4;
            3'd2: return 32'(e);
            3'd3: return 32'(e * 4);
            3'd4: return 32'(longint'(imm) * 65536);
            3'd5: return 32'(sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Capture the handshake seen during this cycle; it takes effect at the next edge
    always @(negedge clk) begin
        pend_v   = rst_n && bus.in_valid && bus.in_ready;
        pend     = cur_exp;
        pend_ill = bus.alu_src_b >= 3'd6;
        fl_s     = flush;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            ill_m = 1'b0;
        end else begin
            if (pend_v && pend_ill) ill_m = 1'b1;
            if (fl_s) exp_q.delete();
            else if (pend_v) exp_q.push_back(pend);
        end
    end

    // Monitor: compare DUT outputs with the reference queue every cycle and retire popped heads
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() != 2));
            chk("illegal_sel", 32'(bus.illegal_sel), 32'(ill_m));
            if (exp_q.size() != 0) begin
                chk("alu_b", bus.alu_b, exp_q[0]);
                if (bus.out_ready && !flush) begin
                    void'(exp_q.pop_front());
                    n_pop++;
                end
            end else begin
                chk("alu_b_idle", bus.alu_b, 32'd0);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_or) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [31:0] rb, input logic [15:0] imm, input logic [5:0] op,
                        input logic [4:0] sh, input logic [2:0] sel, input logic [31:0] e);
        int t;
        t = 0;
        bus.register_b = rb;
        bus.immediate  = imm;
        bus.opcode     = op;
        bus.shamt      = sh;
        bus.alu_src_b  = sel;
        cur_exp        = e;
        bus.in_valid   = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 200);
        if (!bus.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.register_b = '0;
        bus.immediate = '0;
        bus.opcode = '0;
        bus.shamt = '0;
        bus.alu_src_b = '0;
        cycles(3);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_alu_b", bus.alu_b, 32'd0);
        chk("reset_illegal", 32'(bus.illegal_sel), 32'd0);
        rst_n = 1'b1;
        cycles(1);

        bus.out_ready = 1'b1;
        send(32'h1234_5678, 16'h8001, 6'h09, 5'd0, 3'd2, 32'hFFFF_8001);
        send(32'h0, 16'h8001, 6'h0D, 5'd0, 3'd2, 32'h0000_8001);
        send(32'h0, 16'hFFFF, 6'h0C, 5'd0, 3'd2, 32'h0000_FFFF);
        send(32'h0, 16'hFFFF, 6'h0E, 5'd0, 3'd2, 32'h0000_FFFF);
        send(32'h0, 16'h8001, 6'h04, 5'd0, 3'd3, 32'hFFFE_0004);
        send(32'h0, 16'h8001, 6'h0F, 5'd0, 3'd4, 32'h8001_0000);
        send(32'h0, 16'h8001, 6'h09, 5'd0, 3'd1, 32'h0000_0004);
        send(32'h0, 16'h8001, 6'h00, 5'd31, 3'd5, 32'h0000_001F);
        send(32'hDEAD_BEEF, 16'h8001, 6'h09, 5'd7, 3'd0, 32'hDEAD_BEEF);
        cycles(3);

        bus.out_ready = 1'b0;
        p0 = n_pop;
        send(32'hA, 16'h0, 6'h0, 5'd0, 3'd0, 32'hA);
        send(32'hB, 16'h0, 6'h0, 5'd0, 3'd0, 32'hB);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        fork
            send(32'hC, 16'h0, 6'h0, 5'd0, 3'd0, 32'hC);
            begin
                cycles(3);
                bus.out_ready = 1'b1;
            end
        join
        cycles(4);
        chk("full_drain_count", 32'(n_pop - p0), 32'd3);

        p0 = n_pop;
        for (int i = 0; i < 20; i++) send(32'h100 + 32'(i), 16'h0, 6'h0, 5'd0, 3'd0, 32'h100 + 32'(i));
        cycles(1);
        chk("stream_count", 32'(n_pop - p0), 32'd20);
        cycles(2);

        bus.out_ready = 1'b0;
        send(32'h11, 16'h0, 6'h0, 5'd0, 3'd0, 32'h11);
        send(32'h22, 16'h0, 6'h0, 5'd0, 3'd0, 32'h22);
        p0 = n_pop;
        bus.register_b = 32'h33;
        bus.alu_src_b = 3'd0;
        cur_exp = 32'h33;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        cycles(3);
        chk("flush_emitted", 32'(n_pop - p0), 32'd0);

        send(32'h55, 16'h1234, 6'h09, 5'd3, 3'd7, 32'd0);
        cycles(2);
        chk("illegal_set", 32'(bus.illegal_sel), 32'd1);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        chk("illegal_after_flush", 32'(bus.illegal_sel), 32'd1);

        rnd_or = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rb;
            logic [15:0] imm;
            logic [5:0] op;
            logic [4:0] sh;
            logic [2:0] sel;
            rb = $urandom;
            imm = 16'($urandom);
            op = 6'($urandom_range(8, 15));
            sh = 5'($urandom);
            sel = 3'($urandom_range(0, 7));
            send(rb, imm, op, sh, sel, model(rb, imm, op, sh, sel));
            if ($urandom_range(0, 3) == 0) cycles(1);
        end
        rnd_or = 1'b0;
        cycles(2);

        bus.out_ready = 1'b0;
        send(32'h77, 16'h0, 6'h0, 5'd0, 3'd0, 32'h77);
        send(32'h88, 16'h0, 6'h0, 5'd0, 3'd0, 32'h88);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("async_rst_alu_b", bus.alu_b, 32'd0);
        chk("async_rst_illegal", 32'(bus.illegal_sel), 32'd0);
        cycles(2);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        cycles(3);
        send(32'h99, 16'h0, 6'h0, 5'd0, 3'd0, 32'h99);
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
